// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Fetch-lookup and execute-update bundle for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int W   = 32,
    parameter int IDX = 4,
    parameter int CW  = 16
);
    logic           f_valid;
    logic [W-1:0]   f_pc;
    logic           pred_valid;
    logic           pred_taken;
    logic [IDX-1:0] pred_idx;
    logic           u_valid;
    logic [IDX-1:0] u_idx;
    logic           u_br_en;
    logic           u_pred;
    logic           mispredict;
    logic [CW-1:0]  misp_cnt;

    modport master (
        output f_valid, f_pc, u_valid, u_idx, u_br_en, u_pred,
        input  pred_valid, pred_taken, pred_idx, mispredict, misp_cnt
    );

    modport slave (
        input  f_valid, f_pc, u_valid, u_idx, u_br_en, u_pred,
        output pred_valid, pred_taken, pred_idx, mispredict, misp_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Bimodal 2-bit counter predictor; define BP_GSHARE_EN to hash
//               the lookup index with a global history register (gshare).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int W   = 32,
    parameter int IDX = 4,
    parameter int CW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);

    localparam int            c_DEPTH   = 2 ** IDX;
    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] c_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]     r_ctr [c_DEPTH];
    logic           r_pred_valid;
    logic           r_pred_taken;
    logic [IDX-1:0] r_pred_idx;
    logic           r_mispredict;
    logic [CW-1:0]  r_misp_cnt;

    logic [IDX-1:0] w_lookup_idx;
    logic [1:0]     w_upd_ctr;
    logic [1:0]     w_upd_next;
    logic           w_misp;
    logic           w_unused;

    assign w_unused = ^{bp.f_pc[W-1:IDX+2], bp.f_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX-1:0] r_ghr;

    // Lookup sees the history as it stands before this cycle's update shifts in.
    assign w_lookup_idx = bp.f_pc[IDX+1:2] ^ r_ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (bp.u_valid) begin
            r_ghr <= {r_ghr[IDX-2:0], bp.u_br_en};
        end
    end
`else
    assign w_lookup_idx = bp.f_pc[IDX+1:2];
`endif

    assign w_upd_ctr = r_ctr[bp.u_idx];
    assign w_misp    = bp.u_valid & (bp.u_br_en ^ bp.u_pred);

    always_comb begin
        w_upd_next = w_upd_ctr;
        if (bp.u_br_en) begin
            if (w_upd_ctr != 2'b11) w_upd_next = w_upd_ctr + 2'b01;
        end else begin
            if (w_upd_ctr != 2'b00) w_upd_next = w_upd_ctr - 2'b01;
        end
    end

    // Non-blocking write means a same-index lookup naturally reads the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) r_ctr[i] <= 2'b01;
        end else if (bp.u_valid) begin
            r_ctr[bp.u_idx] <= w_upd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
            r_mispredict <= 1'b0;
            r_misp_cnt   <= '0;
        end else begin
            r_pred_valid <= bp.f_valid;
            if (bp.f_valid) begin
                r_pred_taken <= r_ctr[w_lookup_idx][1];
                r_pred_idx   <= w_lookup_idx;
            end
            r_mispredict <= w_misp;
            if (w_misp && (r_misp_cnt != c_CNT_MAX)) begin
                r_misp_cnt <= r_misp_cnt + c_CNT_ONE;
            end
        end
    end

    assign bp.pred_valid = r_pred_valid;
    assign bp.pred_taken = r_pred_taken;
    assign bp.pred_idx   = r_pred_idx;
    assign bp.mispredict = r_mispredict;
    assign bp.misp_cnt   = r_misp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor (CW=16 and CW=4 units).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic clk;
    logic rst;

    branch_predictor_if #(.W(32), .IDX(4), .CW(16)) bus  ();
    branch_predictor_if #(.W(32), .IDX(4), .CW(4))  bus4 ();

    branch_predictor #(.W(32), .IDX(4), .CW(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    branch_predictor #(.W(32), .IDX(4), .CW(4)) u_dut_cw4 (
        .clk (clk),
        .rst (rst),
        .bp  (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic        pt;
        logic [3:0]  pi;
        logic        mp;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [1:0]  m_ctr [16];
    logic [3:0]  m_ghr;
    logic        m_pt;
    logic [3:0]  m_pi;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ctr[i] = 2'b01;
        m_ghr = '0;
        m_pt  = 1'b0;
        m_pi  = '0;
        m_cnt = '0;
        sb.delete();
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
        check("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        check("rst_pred_idx",   32'(bus.pred_idx),   32'd0);
        check("rst_mispredict", 32'(bus.mispredict), 32'd0);
        check("rst_misp_cnt",   32'(bus.misp_cnt),   32'd0);
        bus.f_valid = 1'b1; bus.f_pc = 32'h4; bus.u_valid = 1'b1;
        bus.u_idx = 4'd1; bus.u_br_en = 1'b1; bus.u_pred = 1'b0;
        @(posedge clk); #1;
        check("rst_discard_valid", 32'(bus.pred_valid), 32'd0);
        check("rst_discard_cnt",   32'(bus.misp_cnt),   32'd0);
        rst = 1'b0;
        bus.f_valid = 1'b0; bus.u_valid = 1'b0;
        model_reset();
    endtask

    task automatic drive_cycle(input logic fv, input logic [31:0] pc, input logic uv,
                               input logic [3:0] ui, input logic br, input logic up);
        exp_t       e;
        logic [3:0] li;
        bus.f_valid = fv; bus.f_pc = pc;
        bus.u_valid = uv; bus.u_idx = ui; bus.u_br_en = br; bus.u_pred = up;
        li = pc[5:2] ^ m_ghr;
        if (fv) begin
            m_pt = m_ctr[li][1];
            m_pi = li;
        end
        e.pv = fv; e.pt = m_pt; e.pi = m_pi; e.mp = uv & (br ^ up);
        if (uv) begin
            if (br && m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'b01;
            if (!br && m_ctr[ui] != 2'b00) m_ctr[ui] = m_ctr[ui] - 2'b01;
`ifdef BP_GSHARE_EN
            m_ghr = {m_ghr[2:0], br};
`endif
            if (e.mp && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        check("pred_valid", 32'(bus.pred_valid), 32'(e.pv));
        check("pred_taken", 32'(bus.pred_taken), 32'(e.pt));
        check("pred_idx",   32'(bus.pred_idx),   32'(e.pi));
        check("mispredict", 32'(bus.mispredict), 32'(e.mp));
        check("misp_cnt",   32'(bus.misp_cnt),   32'(e.cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        bus.f_valid = 1'b0; bus.f_pc = '0; bus.u_valid = 1'b0;
        bus.u_idx = '0; bus.u_br_en = 1'b0; bus.u_pred = 1'b0;
        bus4.f_valid = 1'b0; bus4.f_pc = '0; bus4.u_valid = 1'b0;
        bus4.u_idx = '0; bus4.u_br_en = 1'b0; bus4.u_pred = 1'b0;
        #1;
        do_reset();

`ifndef BP_GSHARE_EN
        // First lookup after reset: weak-NT at index 0.
        drive_cycle(1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0);
        check("first_lookup_taken", 32'(bus.pred_taken), 32'd0);
        check("first_lookup_idx",   32'(bus.pred_idx),   32'd0);
        check("first_lookup_valid", 32'(bus.pred_valid), 32'd1);

        drive_cycle(1'b0, 32'h0, 1'b1, 4'd0, 1'b1, 1'b0);
        check("misp_pulse_1", 32'(bus.mispredict), 32'd1);
        drive_cycle(1'b0, 32'h0, 1'b1, 4'd0, 1'b1, 1'b0);
        check("misp_pulse_2", 32'(bus.mispredict), 32'd1);
        drive_cycle(1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0);
        check("trained_taken", 32'(bus.pred_taken), 32'd1);
        check("misp_cnt_two",  32'(bus.misp_cnt),   32'd2);
        check("misp_pulse_end", 32'(bus.mispredict), 32'd0);

        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b1, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0);
        check("idx3_weak_taken", 32'(bus.pred_taken), 32'd1);
        check("idx3_idx",        32'(bus.pred_idx),   32'd3);
        drive_cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0);
        check("idx3_back_to_nt", 32'(bus.pred_taken), 32'd0);

        drive_cycle(1'b0, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0);
        check("hold_valid_low", 32'(bus.pred_valid), 32'd0);
        check("hold_idx",       32'(bus.pred_idx),   32'd3);

        do_reset();
        drive_cycle(1'b1, 32'h40, 1'b1, 4'd0, 1'b1, 1'b0);
        check("collide_old_value", 32'(bus.pred_taken), 32'd0);
        drive_cycle(1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0);
        check("collide_committed", 32'(bus.pred_taken), 32'd1);
`else
        drive_cycle(1'b0, 32'h0, 1'b1, 4'd1, 1'b1, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b1, 4'd2, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b1, 1'b1);
        drive_cycle(1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0);
        check("gshare_idx", 32'(bus.pred_idx), 32'd5);
`endif

        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
        end

        do_reset();
        for (int i = 1; i <= 20; i++) begin
            bus4.u_valid = 1'b1; bus4.u_idx = 4'(i); bus4.u_br_en = 1'b1; bus4.u_pred = 1'b0;
            @(posedge clk); #1;
            if (i == 1 || i == 14 || i == 15 || i == 16 || i == 20) begin
                check("cw4_misp_cnt", 32'(bus4.misp_cnt), (i < 15) ? 32'(i) : 32'd15);
            end
            if (i == 20) check("cw4_mispredict", 32'(bus4.mispredict), 32'd1);
        end
        bus4.u_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter W, default 32, PC width.
REQ-002 SHALL have parameter IDX, default 4, table index width; the table holds 2^IDX entries.
REQ-003 SHALL have parameter CW, default 16, width of the mispredict statistics counter.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 SHALL have port f_valid, input, 1 bit, fetch lookup request.
REQ-007 SHALL have port f_pc, input, W bits, fetch PC.
REQ-008 SHALL have port pred_valid, output, 1 bit, prediction valid, registered.
REQ-009 SHALL have port pred_taken, output, 1 bit, predicted direction, registered.
REQ-010 SHALL have port pred_idx, output, IDX bits, table index used for the prediction, registered.
REQ-011 SHALL have port u_valid, input, 1 bit, resolved conditional branch from execute.
REQ-012 SHALL have port u_idx, input, IDX bits, pred_idx carried down the pipe with the branch.
REQ-013 SHALL have port u_br_en, input, 1 bit, actual outcome from the branch comparator.
REQ-014 SHALL have port u_pred, input, 1 bit, pred_taken carried down the pipe with the branch.
REQ-015 SHALL have port mispredict, output, 1 bit, one-cycle flush pulse, registered.
REQ-016 SHALL have port misp_cnt, output, CW bits, saturating mispredict count.

Function
REQ-017 SHALL implement a table of 2^IDX 2-bit saturating counters in flops: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 SHALL use base index f_pc[IDX+1:2]; bits [1:0] are ignored.
REQ-019 SHALL, at the edge where f_valid=1, register pred_valid=1, pred_idx=lookup index and pred_taken=counter[index][1]; latency is exactly 1 cycle.
REQ-020 SHALL register pred_valid=0 when f_valid=0; pred_taken and pred_idx then hold their previous values.
REQ-021 SHALL, at the edge where u_valid=1, increment counter[u_idx] if u_br_en=1 (saturating at 11) and decrement it otherwise (saturating at 00).
REQ-022 SHALL register mispredict = u_valid & (u_br_en ^ u_pred) and hold it for exactly one cycle per update.
REQ-023 SHALL increment misp_cnt on each mispredict, saturating at all-ones with no wrap.
REQ-024 SHALL, when a lookup and an update hit the same index in the same cycle, return the pre-update counter value to the lookup; the update still commits.
REQ-025 SHALL accept one lookup and one update per cycle with no stalls and no backpressure.
REQ-026 SHALL ignore u_idx, u_br_en and u_pred when u_valid=0.

Reset
REQ-027 SHALL, on rst=1 and independent of clk, set all counters to 01, pred_valid=0, pred_taken=0, pred_idx=0, mispredict=0 and misp_cnt=0.
REQ-028 SHALL discard any lookup or update coincident with rst; normal operation resumes at the first edge after rst falls.

Configuration
REQ-029 SHALL, when macro BP_GSHARE_EN is defined, keep an IDX-bit global history register (GHR) that is reset to 0 and shifts u_br_en in at the LSB on every u_valid.
REQ-030 SHALL, with BP_GSHARE_EN defined, use lookup index f_pc[IDX+1:2] ^ GHR, where GHR is its pre-update value in the cycle of the lookup.
REQ-031 SHALL, without BP_GSHARE_EN, omit the GHR and use lookup index f_pc[IDX+1:2]; update indexing via u_idx is identical in both builds.

Verification
REQ-032 SHALL verify: rst pulse, then f_valid with f_pc=0x40 -> next cycle pred_valid=1, pred_taken=0, pred_idx=0.
REQ-033 SHALL verify: two updates to u_idx=0 with u_br_en=1, u_pred=0, then lookup f_pc=0x40 -> pred_taken=1; mispredict pulses twice; misp_cnt=2.
REQ-034 SHALL verify: five taken updates to index 3, then one not-taken update -> counter[3]=10 and a lookup of f_pc=0x0C returns pred_taken=1.
REQ-035 SHALL verify: lookup of f_pc=0x40 and a taken update at u_idx=0 in the same cycle, counter at 01 -> pred_taken=0, and a following lookup returns 1.
REQ-036 SHALL verify: CW=4 with 20 mispredicts -> misp_cnt holds at 15.
REQ-037 SHALL verify: with BP_GSHARE_EN, updates with outcomes 1, 0 then 1 give GHR=0101, and lookup f_pc=0x40 returns pred_idx=5.
